// File: rtl/gon_pkg.sv
// Shared GON scheduler types: FSM state encoding, the tags FIFO word layout
// and default field widths.
package gon_pkg;

    localparam int GON_ROW_TAG_W = 4;
    localparam int GON_COL_TAG_W = 4;
    localparam int GON_REP_W     = 8;
    localparam int GON_PEND_W    = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } gon_sched_state_t;

    // Column tag sits in the upper half, matching the wrapper's {col_tag,row_tag} word.
    typedef struct packed {
        logic [GON_COL_TAG_W-1:0] col;
        logic [GON_ROW_TAG_W-1:0] row;
    } gon_tag_t;

endpackage

// File: rtl/gon_region_cnt.sv
// Nested repeat/column/row counter walking a PE region in row-major order;
// advances one beat per accepted write and flags the final beat.
module gon_region_cnt #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int REP_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    input  logic [ROW_TAG_WIDTH:0]   num_rows,
    input  logic [COL_TAG_WIDTH:0]   num_cols,
    input  logic [REP_WIDTH-1:0]     num_rep,
    output logic [ROW_TAG_WIDTH:0]   row_cnt,
    output logic [COL_TAG_WIDTH:0]   col_cnt,
    output logic                     last
);

    logic [REP_WIDTH-1:0] rep_cnt;
    logic                 rep_last;
    logic                 col_last;
    logic                 row_last;

    assign rep_last = (rep_cnt == num_rep - REP_WIDTH'(1));
    assign col_last = (col_cnt == num_cols - (COL_TAG_WIDTH + 1)'(1));
    assign row_last = (row_cnt == num_rows - (ROW_TAG_WIDTH + 1)'(1));
    assign last     = rep_last & col_last & row_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rep_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (advance) begin
            if (!rep_last) begin
                rep_cnt <= rep_cnt + REP_WIDTH'(1);
            end else begin
                rep_cnt <= '0;
                if (!col_last) begin
                    col_cnt <= col_cnt + (COL_TAG_WIDTH + 1)'(1);
                end else begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + (ROW_TAG_WIDTH + 1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gon_tag_sched.sv
// GON tag scheduler: streams {col_tag,row_tag} pairs for a PE region into the
// tags FIFO. Define GON_TAG_SCHED_DRAIN_EN to hold completion until data drains.
module gon_tag_sched
    import gon_pkg::*;
#(
    parameter int ROW_TAG_WIDTH = GON_ROW_TAG_W,
    parameter int COL_TAG_WIDTH = GON_COL_TAG_W,
    parameter int REP_WIDTH     = GON_REP_W,
    parameter int PEND_WIDTH    = GON_PEND_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_row_base,
    input  logic [ROW_TAG_WIDTH:0]   cfg_num_rows,
    input  logic [COL_TAG_WIDTH-1:0] cfg_col_base,
    input  logic [COL_TAG_WIDTH:0]   cfg_num_cols,
    input  logic [REP_WIDTH-1:0]     cfg_repeat,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     tags_wr_en,
    input  logic                     tags_full,
    input  logic                     data_rd_en,
    input  logic                     data_empty,
    output logic                     busy,
    output logic                     done
);

    gon_sched_state_t state;
    gon_sched_state_t state_next;

    logic [ROW_TAG_WIDTH-1:0] row_base;
    logic [ROW_TAG_WIDTH:0]   num_rows;
    logic [COL_TAG_WIDTH-1:0] col_base;
    logic [COL_TAG_WIDTH:0]   num_cols;
    logic [REP_WIDTH-1:0]     num_rep;
    logic [ROW_TAG_WIDTH:0]   row_cnt;
    logic [COL_TAG_WIDTH:0]   col_cnt;
    logic                     cnt_last;
    logic                     job_start;
    logic                     cfg_zero;
    logic                     fin_hold;

    assign job_start = (state == ST_IDLE) && start;
    assign cfg_zero  = (cfg_num_rows == '0) || (cfg_num_cols == '0) || (cfg_repeat == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            row_base <= '0;
            num_rows <= '0;
            col_base <= '0;
            num_cols <= '0;
            num_rep  <= '0;
        end else if (job_start) begin
            row_base <= cfg_row_base;
            num_rows <= cfg_num_rows;
            col_base <= cfg_col_base;
            num_cols <= cfg_num_cols;
            num_rep  <= cfg_repeat;
        end
    end

    gon_region_cnt #(
        .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
        .COL_TAG_WIDTH (COL_TAG_WIDTH),
        .REP_WIDTH     (REP_WIDTH)
    ) u_region_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (job_start),
        .advance  (tags_wr_en),
        .num_rows (num_rows),
        .num_cols (num_cols),
        .num_rep  (num_rep),
        .row_cnt  (row_cnt),
        .col_cnt  (col_cnt),
        .last     (cnt_last)
    );

    assign row_tag = row_base + row_cnt[ROW_TAG_WIDTH-1:0];
    assign col_tag = col_base + col_cnt[COL_TAG_WIDTH-1:0];

`ifdef GON_TAG_SCHED_DRAIN_EN
    logic [PEND_WIDTH-1:0] pend;
    logic                  pend_dec;

    assign pend_dec = data_rd_en & ~data_empty;

    always_ff @(posedge clk) begin
        if (reset || job_start) begin
            pend <= '0;
        end else if (tags_wr_en && !pend_dec) begin
            pend <= pend + PEND_WIDTH'(1);
        end else if (!tags_wr_en && pend_dec && (pend != '0)) begin
            pend <= pend - PEND_WIDTH'(1);
        end
    end
`else
    logic [PEND_WIDTH-1:0] unused_pend;
    logic                  unused_data;
    assign unused_pend = '0;
    assign unused_data = data_rd_en ^ data_empty;
`endif

    // Zero-count jobs spend one extra cycle in FIN so done lands two cycles after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_hold <= 1'b0;
        end else if (job_start) begin
            fin_hold <= cfg_zero;
        end else if (state == ST_FIN) begin
            fin_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = cfg_zero ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tags_wr_en && cnt_last) begin
`ifdef GON_TAG_SCHED_DRAIN_EN
                    state_next = ST_DRAIN;
`else
                    state_next = ST_FIN;
`endif
                end
            end
            ST_DRAIN: begin
`ifdef GON_TAG_SCHED_DRAIN_EN
                if (pend == '0) begin
                    state_next = ST_FIN;
                end
`else
                state_next = ST_FIN;
`endif
            end
            ST_FIN: begin
                if (!fin_hold) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tags_wr_en = (state == ST_ISSUE) && !tags_full;
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIN) && !fin_hold;
    end

endmodule

// File: tb/tb_gon_tag_sched.sv
// Directed bench for gon_tag_sched: table-driven jobs plus reset, start-while-busy
// and (when GON_TAG_SCHED_DRAIN_EN is defined) drain sequences.
module tb_gon_tag_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cfg_row_base = '0;
    logic [4:0] cfg_num_rows = '0;
    logic [3:0] cfg_col_base = '0;
    logic [4:0] cfg_num_cols = '0;
    logic [7:0] cfg_repeat = '0;
    logic [3:0] row_tag;
    logic [3:0] col_tag;
    logic       tags_wr_en;
    logic       tags_full = 1'b0;
    logic       data_rd_en = 1'b0;
    logic       data_empty = 1'b1;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

`ifdef GON_TAG_SCHED_DRAIN_EN
    localparam int DRAIN_EXTRA = 1;
`else
    localparam int DRAIN_EXTRA = 0;
`endif

    gon_tag_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_row_base (cfg_row_base),
        .cfg_num_rows (cfg_num_rows),
        .cfg_col_base (cfg_col_base),
        .cfg_num_cols (cfg_num_cols),
        .cfg_repeat   (cfg_repeat),
        .row_tag      (row_tag),
        .col_tag      (col_tag),
        .tags_wr_en   (tags_wr_en),
        .tags_full    (tags_full),
        .data_rd_en   (data_rd_en),
        .data_empty   (data_empty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rb;
        logic [4:0] nr;
        logic [3:0] cb;
        logic [4:0] nc;
        logic [7:0] rep;
        int         stall_at;
        int         stall_len;
        int         poke_at;
        int         exp_wr;
        int         exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic scramble_cfg();
        cfg_row_base = 4'($urandom);
        cfg_num_rows = 5'($urandom_range(1, 31));
        cfg_col_base = 4'($urandom);
        cfg_num_cols = 5'($urandom_range(1, 31));
        cfg_repeat   = 8'($urandom_range(1, 255));
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after done.
    task automatic run_job(input string tag, input vec_t v);
        int         exp_r[$];
        int         exp_c[$];
        int         wr;
        int         done_cyc;
        int         cyc;
        logic       stall;
        logic [3:0] t;
        for (int r = 0; r < int'(v.nr); r++)
            for (int c = 0; c < int'(v.nc); c++)
                for (int k = 0; k < int'(v.rep); k++) begin
                    t = 4'(int'(v.rb) + r); exp_r.push_back(int'(t));
                    t = 4'(int'(v.cb) + c); exp_c.push_back(int'(t));
                end
        wr = 0;
        done_cyc = -1;
        cfg_row_base = v.rb; cfg_num_rows = v.nr;
        cfg_col_base = v.cb; cfg_num_cols = v.nc;
        cfg_repeat = v.rep;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_cfg();
        cyc = 1;
        while (cyc <= 200 && done_cyc < 0) begin
            stall = (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len);
            tags_full = stall;
            start = (cyc == v.poke_at);
            #1;
            if (stall) begin
                chk({tag, "_stall_wr"}, int'(tags_wr_en), 0);
                if (wr < exp_r.size()) begin
                    chk({tag, "_stall_row"}, int'(row_tag), exp_r[wr]);
                    chk({tag, "_stall_col"}, int'(col_tag), exp_c[wr]);
                end
            end
            if (tags_wr_en) begin
                if (wr < exp_r.size()) begin
                    chk({tag, "_row"}, int'(row_tag), exp_r[wr]);
                    chk({tag, "_col"}, int'(col_tag), exp_c[wr]);
                end
                wr++;
            end
            chk({tag, "_busy"}, int'(busy), 1);
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        tags_full = 1'b0;
        start = 1'b0;
        chk({tag, "_writes"}, wr, v.exp_wr);
        chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        // rb nr cb nc rep | stall_at len | poke | writes done
        vecs[0] = '{4'd1,  5'd2, 4'd4, 5'd3, 8'd1, 0, 0, 0, 6, 7};
        vecs[1] = '{4'd0,  5'd1, 4'd0, 5'd2, 8'd2, 0, 0, 2, 4, 5};
        vecs[2] = '{4'd2,  5'd2, 4'd3, 5'd2, 8'd1, 3, 5, 0, 4, 10};
        vecs[3] = '{4'd15, 5'd2, 4'd0, 5'd1, 8'd1, 0, 0, 0, 2, 3};
        vecs[4] = '{4'd3,  5'd2, 4'd1, 5'd0, 8'd1, 0, 0, 0, 0, 2};
        vecs[5] = '{4'd3,  5'd0, 4'd1, 5'd2, 8'd3, 0, 0, 0, 0, 2};
        vecs[6] = '{4'd3,  5'd1, 4'd1, 5'd2, 8'd0, 0, 0, 0, 0, 2};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_wr_en", int'(tags_wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_row_tag", int'(row_tag), 0);
        chk("rst_col_tag", int'(col_tag), 0);
        @(posedge clk); #1;

`ifdef GON_TAG_SCHED_DRAIN_EN
        data_rd_en = 1'b1;
        data_empty = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            vec_t v;
            v = vecs[i];
            if (v.exp_wr > 0) v.exp_done = v.exp_done + DRAIN_EXTRA;
            run_job($sformatf("vec%0d", i), v);
        end

        // Reset in the middle of ISSUE, then a clean job.
        cfg_row_base = 4'd0; cfg_num_rows = 5'd3;
        cfg_col_base = 4'd0; cfg_num_cols = 5'd3; cfg_repeat = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_wr_en", int'(tags_wr_en), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_row_tag", int'(row_tag), 0);
        begin
            vec_t v;
            v = vecs[0];
            v.exp_done = v.exp_done + DRAIN_EXTRA;
            run_job("after_rst", v);
        end

`ifdef GON_TAG_SCHED_DRAIN_EN
        // Drain: 4 writes with reads withheld, then reads release completion.
        data_rd_en = 1'b0;
        data_empty = 1'b0;
        cfg_row_base = 4'd0; cfg_num_rows = 5'd1;
        cfg_col_base = 4'd0; cfg_num_cols = 5'd4; cfg_repeat = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("drn_wr", int'(tags_wr_en), 1);
            @(posedge clk); #1;
        end
        for (int c = 0; c < 6; c++) begin
            chk("drn_wait_busy", int'(busy), 1);
            chk("drn_wait_done", int'(done), 0);
            @(posedge clk); #1;
        end
        data_rd_en = 1'b1;
        data_empty = 1'b1;
        @(posedge clk); #1;
        data_empty = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("drn_read_done", int'(done), 0);
            @(posedge clk); #1;
        end
        data_rd_en = 1'b0;
        chk("drn_settle_done", int'(done), 0);
        chk("drn_settle_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("drn_done", int'(done), 1);
        @(posedge clk); #1;
        chk("drn_idle", int'(busy), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
